pc_ctrl: RTL
============

# pc_ctrl

Program-counter controller for the 16-bit RISC core. Owns the PC register and the interrupt return address. Drives the select of the three-input next-PC selector and resolves competing redirects: branch, jump, interrupt entry and interrupt return. Emits a one-cycle flush to the fetch/decode stages after every redirect.

## Interface
Parameters:
- AW, 16, address width of the PC.
- RESET_VEC, 16'h0000, PC value loaded on reset.
- IRQ_VEC, 16'h0004, interrupt service entry address.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold the PC (pipeline hazard).
- br_taken  in  1  branch resolved taken this cycle.
- br_target  in  AW  branch destination.
- jmp  in  1  unconditional jump decoded this cycle.
- jmp_target  in  AW  jump destination.
- irq_req  in  1  level interrupt request.
- iret  in  1  return-from-interrupt decoded this cycle.
- pc  out  AW  current fetch address (registered).
- pc_sel  out  2  next-PC select, combinational: 0 = pc+1, 1 = branch target, 2 = jump/vector/epc; 3 is never driven.
- flush  out  1  kill the instruction currently in fetch/decode (registered).
- irq_ack  out  1  one-cycle pulse on interrupt entry (registered).
- epc  out  AW  saved return address (registered).
- in_isr  out  1  interrupt mask; high while servicing an interrupt.

## Operation
States are BOOT, RUN and FLUSH.

- **BOOT:** entered on reset. Holds pc = RESET_VEC and drives pc_sel = 0. Moves to RUN after one cycle.
- **RUN:** evaluates events in priority order; the first match wins.
  1. br_taken: pc <= br_target, pc_sel = 1, go to FLUSH.
  2. jmp: pc <= jmp_target, pc_sel = 2, go to FLUSH.
  3. iret with in_isr = 1: pc <= epc, pc_sel = 2, in_isr <= 0, go to FLUSH.
  4. irq_req with in_isr = 0 and stall = 0: epc <= pc, pc <= IRQ_VEC, pc_sel = 2, irq_ack <= 1, in_isr <= 1, go to FLUSH.
  5. stall: pc held, pc_sel = 0, no update.
  6. Otherwise: pc <= pc + 1.
- **FLUSH:** flush = 1 for exactly this cycle. br_taken, jmp, iret and irq_req are ignored, because they belong to killed instructions. pc advances by 1 unless stall. Always returns to RUN.

Boundary rules:
- Redirects override stall.
- pc + 1 wraps modulo 2^AW (FFFF -> 0000).
- iret with in_isr = 0 is a no-op (sequential).
- No nesting: irq_req is ignored while in_isr = 1.
- When iret and irq_req occur together, iret is taken and the interrupt is accepted at the earliest following RUN cycle with no stall.

## Timing
Reset values:
- pc = RESET_VEC, epc = 0.
- flush = 0, irq_ack = 0, in_isr = 0, pc_sel = 0.
- State = BOOT.

Cycle behaviour:
- pc_sel is combinational from the current state and inputs, in the same cycle as the request.
- A redirect request in cycle N gives the new pc after edge N, with flush = 1 during cycle N+1.
- irq_ack pulses during cycle N+1.
- Redirect latency is 1 cycle, plus 1 bubble.
- Reset asserted mid-operation (including inside an ISR or FLUSH) clears immediately, with no clock required.

## Configuration
- PC_CTRL_IRQ_EN defined: interrupt entry, iret, epc and in_isr behave as specified above.
- Undefined: irq_req and iret are ignored; irq_ack, in_isr and epc are tied to 0. Ports are retained for pin compatibility.

## Structure
- Shared package pc_ctrl_pkg holds:
  - select constants SEL_SEQ = 2'd0, SEL_BR = 2'd1, SEL_JV = 2'd2;
  - state encoding BOOT / RUN / FLUSH;
  - default RESET_VEC and IRQ_VEC.
- One sub-module instance, pc_mux, the existing three-input next-PC selector:
  - in_1 = pc + 1;
  - in_2 = br_target;
  - in_3 = a local 3:1 choice of jmp_target / IRQ_VEC / epc;
  - control = pc_sel.

## Test plan
- Assert rst for 3 cycles, then release -> pc = 0000 for BOOT plus the first RUN cycle, then 0001, 0002. flush, irq_ack and in_isr stay 0.
- Preload pc = FFFE and run 3 cycles with no events -> pc = FFFF, 0000, 0001.
- stall = 1 for 2 cycles at pc = 0010 -> pc holds 0010 for 2 cycles, then 0011. pc_sel = 0 throughout.
- At pc = 0020, br_taken = 1 (br_target = 0100) with jmp = 1 (jmp_target = 0200) and stall = 1 -> pc_sel = 1, next pc = 0100, flush = 1 for one cycle. A jmp during that FLUSH cycle is ignored and pc = 0101.
- With the macro defined, irq_req at pc = 0030 -> epc = 0030, pc = 0004, irq_ack pulses once, in_isr = 1. A second irq_req is ignored. iret -> pc = 0030, in_isr = 0, flush pulses.
- rst asserted mid-ISR (pc = 0006, in_isr = 1) -> asynchronously pc = 0000, epc = 0000, in_isr = 0, state BOOT.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// Shared constants for the PC controller: next-PC select codes, FSM states, default vectors.
package pc_ctrl_pkg;

  localparam logic [1:0] SEL_SEQ = 2'd0;
  localparam logic [1:0] SEL_BR  = 2'd1;
  localparam logic [1:0] SEL_JV  = 2'd2;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [15:0] DEF_RESET_VEC = 16'h0000;
  localparam logic [15:0] DEF_IRQ_VEC   = 16'h0004;

endpackage

// File: rtl/pc_mux.sv
// Three-input next-PC selector; code 3 is never issued and falls back to the sequential input.
module pc_mux
  import pc_ctrl_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic [AW-1:0] in_1,
  input  logic [AW-1:0] in_2,
  input  logic [AW-1:0] in_3,
  input  logic [1:0]    sel,
  output logic [AW-1:0] out
);

  always_comb begin
    out = in_1;
    case (sel)
      SEL_BR:  out = in_2;
      SEL_JV:  out = in_3;
      default: out = in_1;
    endcase
  end

endmodule

// File: rtl/pc_ctrl.sv
// PC controller: owns pc/epc, arbitrates branch > jump > iret > irq, flushes one cycle per redirect.
// Interrupt support is compiled in only when PC_CTRL_IRQ_EN is defined.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int          AW        = 16,
  parameter logic [AW-1:0] RESET_VEC = AW'(DEF_RESET_VEC),
  parameter logic [AW-1:0] IRQ_VEC   = AW'(DEF_IRQ_VEC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  input  logic          jmp,
  input  logic [AW-1:0] jmp_target,
  input  logic          irq_req,
  input  logic          iret,
  output logic [AW-1:0] pc,
  output logic [1:0]    pc_sel,
  output logic          flush,
  output logic          irq_ack,
  output logic [AW-1:0] epc,
  output logic          in_isr
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_epc;
  logic          r_flush;
  logic          r_irq_ack;
  logic          r_in_isr;

  logic          w_iret_ok;
  logic          w_irq_ok;
  logic          w_take_iret;
  logic          w_take_irq;
  logic          w_ld_pc;
  logic [1:0]    w_sel;
  logic [AW-1:0] w_pc_inc;
  logic [AW-1:0] w_jv_src;
  logic [AW-1:0] w_pc_nxt;

`ifdef PC_CTRL_IRQ_EN
  assign w_iret_ok = iret & r_in_isr;
  assign w_irq_ok  = irq_req & ~r_in_isr & ~stall;
`else
  logic w_unused_irq;
  assign w_unused_irq = irq_req ^ iret;
  assign w_iret_ok    = 1'b0;
  assign w_irq_ok     = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_sel       = SEL_SEQ;
    w_ld_pc     = 1'b0;
    w_take_iret = 1'b0;
    w_take_irq  = 1'b0;
    case (r_state)
      BOOT: w_state_nxt = RUN;
      RUN: begin
        if (br_taken) begin
          w_sel       = SEL_BR;
          w_ld_pc     = 1'b1;
          w_state_nxt = FLUSH;
        end else if (jmp || w_iret_ok || w_irq_ok) begin
          w_sel       = SEL_JV;
          w_ld_pc     = 1'b1;
          w_take_iret = ~jmp & w_iret_ok;
          w_take_irq  = ~jmp & ~w_iret_ok & w_irq_ok;
          w_state_nxt = FLUSH;
        end else begin
          w_ld_pc = ~stall;
        end
      end
      // Requests seen here belong to the killed instruction.
      FLUSH: begin
        w_ld_pc     = ~stall;
        w_state_nxt = RUN;
      end
      default: w_state_nxt = BOOT;
    endcase
  end

  assign w_pc_inc = r_pc + AW'(1);
  assign w_jv_src = jmp ? jmp_target : (w_take_iret ? r_epc : IRQ_VEC);

  pc_mux #(.AW(AW)) u_pc_mux (
    .in_1 (w_pc_inc),
    .in_2 (br_target),
    .in_3 (w_jv_src),
    .sel  (w_sel),
    .out  (w_pc_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= BOOT;
      r_pc      <= RESET_VEC;
      r_epc     <= '0;
      r_flush   <= 1'b0;
      r_irq_ack <= 1'b0;
      r_in_isr  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_flush   <= (w_state_nxt == FLUSH);
      r_irq_ack <= w_take_irq;
      if (w_ld_pc) r_pc <= w_pc_nxt;
      if (w_take_irq) begin
        r_epc    <= r_pc;
        r_in_isr <= 1'b1;
      end else if (w_take_iret) begin
        r_in_isr <= 1'b0;
      end
    end
  end

  assign pc      = r_pc;
  assign pc_sel  = w_sel;
  assign flush   = r_flush;
  assign irq_ack = r_irq_ack;
  assign epc     = r_epc;
  assign in_isr  = r_in_isr;

endmodule
